// File: rtl/map_pkg.sv
// Shared definitions for the tile-map scroller: map geometry, block_state
// encodings, the two FSM state types and a lane clamp helper.
package map_pkg;

    localparam int MAP_ROWS    = 5;
    localparam int MAP_COLS    = 100;
    localparam int TILE_W_LOG2 = 5;
    localparam int LANE_H      = 96;
    localparam int SCREEN_W    = 640;
    localparam int PLAYER_X    = 64;
    localparam int MAX_SCROLL  = MAP_COLS * (1 << TILE_W_LOG2) - SCREEN_W;

    // block_state encodings returned by the tile map
    localparam logic [2:0] ST_GAP     = 3'b000;
    localparam logic [2:0] ST_SOLID   = 3'b001;
    localparam logic [2:0] ST_SPECIAL = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } scroll_state_t;

    typedef enum logic {
        SCAN  = 1'b0,
        PROBE = 1'b1
    } port_state_t;

    // Out-of-range lane numbers read the bottom lane
    function automatic logic [2:0] clamp_lane(input logic [2:0] lane);
        return (lane > 3'(MAP_ROWS - 1)) ? 3'(MAP_ROWS - 1) : lane;
    endfunction

endpackage

// File: rtl/map_scroller_lane_decode.sv
// lane_decode: pixel y to lane number through a compare chain (no divider).
// Rows at or below the map bottom flag out_of_lane and report the last lane
// so the map is still addressed with a legal row.
module lane_decode
    import map_pkg::*;
(
    input  logic [9:0] pix_y,
    output logic [2:0] lane,
    output logic       out_of_lane
);

    // Compare chain against lane boundaries 96/192/288/384/480
    always_comb begin
        lane        = 3'(MAP_ROWS - 1);
        out_of_lane = 1'b0;
        if (pix_y < 10'(LANE_H)) begin
            lane = 3'd0;
        end else if (pix_y < 10'(2 * LANE_H)) begin
            lane = 3'd1;
        end else if (pix_y < 10'(3 * LANE_H)) begin
            lane = 3'd2;
        end else if (pix_y < 10'(4 * LANE_H)) begin
            lane = 3'd3;
        end else if (pix_y < 10'(5 * LANE_H)) begin
            lane = 3'd4;
        end else begin
            out_of_lane = 1'b1;
        end
    end

endmodule

// File: rtl/map_scroller.sv
// map_scroller: turns VGA pixel coordinates plus a per-frame horizontal
// scroll into tile-map addresses, registers the returned colour, and once
// per frame (in vertical blank) probes the tile under the player column.
//
// Handshake: there is no valid/ready flow here. pix_* are qualified by
// pix_de every cycle; frame_start is a single-cycle strobe; probe_state is
// qualified by the one-cycle probe_valid pulse and holds between pulses.
module map_scroller
    import map_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        pix_de,
    input  logic        frame_start,
    input  logic        run,
    input  logic        restart,
    input  logic [3:0]  speed,
    input  logic [2:0]  probe_lane,
    output logic [2:0]  index_y,
    output logic [6:0]  index_x,
    input  logic [3:0]  map_r,
    input  logic [3:0]  map_g,
    input  logic [3:0]  map_b,
    input  logic [2:0]  map_state,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_de,
    output logic [11:0] scroll_pos,
    output logic        end_of_map,
    output logic [2:0]  probe_state,
    output logic        probe_valid,
    output logic [1:0]  dbg_scroll_state,
    output logic        dbg_port_state
);

    localparam logic [12:0] MAX_SCROLL_W = 13'(MAX_SCROLL);

    scroll_state_t scroll_state_q, scroll_state_d;
    port_state_t   port_state_q, port_state_d;
    logic [11:0]   scroll_q, scroll_d;
    logic [12:0]   scroll_sum;

    // Pixel pipeline stage S0
    logic          de_s0_q, de_s0_d;
    logic [2:0]    lane_q, lane_d;
    logic          oob_q, oob_d;
    logic [11:0]   world_x_q, world_x_d;

    // Probe column, computed from the pre-update scroll in the frame_start cycle
    logic [6:0]    probe_col_q, probe_col_d;
    logic [11:0]   probe_world;

    // Output registers
    logic [3:0]    vga_r_q, vga_r_d;
    logic [3:0]    vga_g_q, vga_g_d;
    logic [3:0]    vga_b_q, vga_b_d;
    logic          vga_de_q, vga_de_d;
    logic [2:0]    probe_state_q, probe_state_d;
    logic          probe_valid_q, probe_valid_d;

    logic [2:0]    dec_lane;
    logic          dec_oob;
    logic          blank;

    lane_decode u_lane_decode (
        .pix_y       (pix_y),
        .lane        (dec_lane),
        .out_of_lane (dec_oob)
    );

    // Scroll FSM next state: moves only on frame_start, restart wins over all
    always_comb begin
        scroll_state_d = scroll_state_q;
        scroll_d       = scroll_q;
        scroll_sum     = {1'b0, scroll_q} + 13'(speed);
        if (restart) begin
            scroll_state_d = IDLE;
            scroll_d       = 12'd0;
        end else if (frame_start) begin
            case (scroll_state_q)
                IDLE: begin
                    scroll_d = 12'd0;
                    if (run) begin
                        scroll_sum = 13'(speed);
                        if (scroll_sum >= MAX_SCROLL_W) begin
                            scroll_d       = MAX_SCROLL_W[11:0];
                            scroll_state_d = DONE;
                        end else begin
                            scroll_d       = scroll_sum[11:0];
                            scroll_state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (run) begin
                        if (scroll_sum >= MAX_SCROLL_W) begin
                            scroll_d       = MAX_SCROLL_W[11:0];
                            scroll_state_d = DONE;
                        end else begin
                            scroll_d = scroll_sum[11:0];
                        end
                    end
                end
                DONE: begin
                    scroll_d = scroll_q;
                end
                default: begin
                    scroll_state_d = IDLE;
                    scroll_d       = 12'd0;
                end
            endcase
        end
    end

    // Read-port FSM next state: one PROBE cycle after each frame_start
    always_comb begin
        port_state_d = port_state_q;
        case (port_state_q)
            SCAN:    if (frame_start) port_state_d = PROBE;
            PROBE:   port_state_d = SCAN;
            default: port_state_d = SCAN;
        endcase
    end

    // Map address mux: the probe borrows the read port for its single cycle
    always_comb begin
        index_y = lane_q;
        index_x = world_x_q[TILE_W_LOG2 +: 7];
        if (port_state_q == PROBE) begin
            index_y = clamp_lane(probe_lane);
            index_x = probe_col_q;
        end
    end

    // Pipeline, probe capture and pixel colour next values
    always_comb begin
        de_s0_d     = pix_de;
        lane_d      = dec_lane;
        oob_d       = dec_oob;
        world_x_d   = {2'b00, pix_x} + scroll_q;

        probe_world = scroll_q + 12'(PLAYER_X);
        probe_col_d = probe_col_q;
        if (frame_start) begin
            probe_col_d = probe_world[TILE_W_LOG2 +: 7];
        end

        blank    = !de_s0_q || oob_q || (map_state == ST_GAP) || (port_state_q == PROBE);
        vga_de_d = de_s0_q && (port_state_q != PROBE);
        vga_r_d  = blank ? 4'd0 : map_r;
        vga_g_d  = blank ? 4'd0 : map_g;
        vga_b_d  = blank ? 4'd0 : map_b;

        probe_state_d = (port_state_q == PROBE) ? map_state : probe_state_q;
        probe_valid_d = (port_state_q == PROBE);
    end

    // State and data registers, synchronous reset flushes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            scroll_state_q <= IDLE;
            port_state_q   <= SCAN;
            scroll_q       <= 12'd0;
            de_s0_q        <= 1'b0;
            lane_q         <= 3'd0;
            oob_q          <= 1'b0;
            world_x_q      <= 12'd0;
            probe_col_q    <= 7'd0;
            vga_r_q        <= 4'd0;
            vga_g_q        <= 4'd0;
            vga_b_q        <= 4'd0;
            vga_de_q       <= 1'b0;
            probe_state_q  <= 3'd0;
            probe_valid_q  <= 1'b0;
        end else begin
            scroll_state_q <= scroll_state_d;
            port_state_q   <= port_state_d;
            scroll_q       <= scroll_d;
            de_s0_q        <= de_s0_d;
            lane_q         <= lane_d;
            oob_q          <= oob_d;
            world_x_q      <= world_x_d;
            probe_col_q    <= probe_col_d;
            vga_r_q        <= vga_r_d;
            vga_g_q        <= vga_g_d;
            vga_b_q        <= vga_b_d;
            vga_de_q       <= vga_de_d;
            probe_state_q  <= probe_state_d;
            probe_valid_q  <= probe_valid_d;
        end
    end

    assign vga_r            = vga_r_q;
    assign vga_g            = vga_g_q;
    assign vga_b            = vga_b_q;
    assign vga_de           = vga_de_q;
    assign scroll_pos       = scroll_q;
    assign end_of_map       = (scroll_state_q == DONE);
    assign probe_state      = probe_state_q;
    assign probe_valid      = probe_valid_q;
    assign dbg_scroll_state = scroll_state_q;
    assign dbg_port_state   = port_state_q;

endmodule
